// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle for the fetch unit.
// Carries the instruction-memory request/response signals, the decode
// valid/ready handshake, and the redirect request from execute.
//   master : the fetch unit (drives imem_pc/read/write and id_*)
//   slave  : the environment (memory, decode, execute)
interface fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] imem_pc;
  logic                imem_read;
  logic                imem_write;
  logic [31:0]         imem_rdata;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_bundle;
  logic [PC_WIDTH-1:0] id_pc;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_pc, imem_read, imem_write, id_valid, id_bundle, id_pc,
    input  imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_pc, imem_read, imem_write, id_valid, id_bundle, id_pc,
    output imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch initiator.
// Issues a read to instruction memory whenever the 2-entry bundle queue has
// room (or is being drained this cycle), captures the combinational 32-bit
// bundle, and presents queued bundles with their PC to decode over a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : fetch_unit_if.master (imem_*, id_*, redirect/redirect_pc)
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_EVEN = {RESET_PC[PC_WIDTH-1:1], 1'b0};
  localparam logic [PC_WIDTH-1:0] STEP          = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]          count_q, count_d;
  logic [31:0]         bundle0_q, bundle0_d;
  logic [31:0]         bundle1_q, bundle1_d;
  logic [PC_WIDTH-1:0] pc0_q, pc0_d;
  logic [PC_WIDTH-1:0] pc1_q, pc1_d;
  logic                pop;
  logic                fire;

  // Entry 0 is always the head presented to decode.
  assign bus.imem_pc    = fetch_pc_q;
  assign bus.imem_read  = fire;
  assign bus.imem_write = 1'b0;
  assign bus.id_valid   = (count_q != 2'd0);
  assign bus.id_bundle  = bundle0_q;
  assign bus.id_pc      = pc0_q;

  // A full queue may still fetch when the head leaves in the same cycle.
  assign pop  = (count_q != 2'd0) & bus.id_ready;
  assign fire = !reset & !bus.redirect & ((count_q != 2'd2) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    bundle0_d  = bundle0_q;
    bundle1_d  = bundle1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    if (bus.redirect) begin
      // Stale entries are dropped by zeroing the count; their data is dead.
      count_d    = 2'd0;
      fetch_pc_d = {bus.redirect_pc[PC_WIDTH-1:1], 1'b0};
    end else begin
      case ({pop, fire})
        2'b11: begin
          if (count_q == 2'd2) begin
            bundle0_d = bundle1_q;
            pc0_d     = pc1_q;
            bundle1_d = bus.imem_rdata;
            pc1_d     = fetch_pc_q;
          end else begin
            bundle0_d = bus.imem_rdata;
            pc0_d     = fetch_pc_q;
          end
        end
        2'b10: begin
          bundle0_d = bundle1_q;
          pc0_d     = pc1_q;
          count_d   = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) begin
            bundle0_d = bus.imem_rdata;
            pc0_d     = fetch_pc_q;
          end else begin
            bundle1_d = bus.imem_rdata;
            pc1_d     = fetch_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        default: begin
        end
      endcase
      if (fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC_EVEN;
      count_q    <= 2'd0;
      bundle0_q  <= '0;
      bundle1_q  <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      bundle0_q  <= bundle0_d;
      bundle1_q  <= bundle1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

endmodule
